mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-request memory controller sitting between the control
// unit (memEN/memWE/mar/mdr -> memOut/R) and an external RAM, with a small
// memory-mapped keyboard/display block decoded at xFE00-xFE06.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   memEN, memWE, mar, mdr  access request, sampled only while idle
//   memOut, R               read data (held until the next read) and
//                           one-cycle completion pulse
//   ext_ce, ext_we          external RAM enable / write strobe
//   ext_addr, ext_wdata     external RAM address / write data
//   ext_rdata               external RAM read data
//   kb_valid, kb_data       keyboard character strobe and character
//   dd_valid, dd_data       display character valid and character
//   dd_ready                display accepts the current character
module mem_ctrl #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memEN,
    input  logic        memWE,
    input  logic [15:0] mar,
    input  logic [15:0] mdr,
    output logic [15:0] memOut,
    output logic        R,
    output logic        ext_ce,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [15:0] ext_wdata,
    input  logic [15:0] ext_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        dd_valid,
    output logic [7:0]  dd_data,
    input  logic        dd_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [15:0] memout_q, memout_d;
    logic        r_q, r_d;
    logic        ext_ce_q, ext_ce_d;
    logic        ext_we_q, ext_we_d;
    logic [7:0]  kbdr_q, kbdr_d;
    logic        kb_ready_q, kb_ready_d;
    logic        dready_q, dready_d;
    logic        dd_valid_q, dd_valid_d;
    logic [7:0]  dd_data_q, dd_data_d;

    logic        kbdr_rd_done;
    logic        ddr_wr_go;
    logic        kb_ready_after_rd;

    function automatic logic is_mmio(input logic [15:0] a);
        return (a == KBSR_ADDR) || (a == KBDR_ADDR) ||
               (a == DSR_ADDR)  || (a == DDR_ADDR);
    endfunction

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        memout_d     = memout_q;
        r_d          = 1'b0;
        ext_ce_d     = ext_ce_q;
        ext_we_d     = ext_we_q;
        kbdr_d       = kbdr_q;
        dready_d     = dready_q;
        dd_valid_d   = dd_valid_q;
        dd_data_d    = dd_data_q;
        kbdr_rd_done = 1'b0;
        ddr_wr_go    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (memEN) begin
                    state_d = ACCESS;
                    addr_d  = mar;
                    wdata_d = mdr;
                    we_d    = memWE;
                    if (is_mmio(mar)) begin
                        cnt_d = 4'd0;
                    end else begin
                        // Strobes are registered, so they rise together
                        // with the first ACCESS cycle.
                        cnt_d    = WAIT_INIT;
                        ext_ce_d = 1'b1;
                        ext_we_d = memWE;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d  = DONE;
                    r_d      = 1'b1;
                    ext_ce_d = 1'b0;
                    ext_we_d = 1'b0;
                    if (!we_q) begin
                        unique case (addr_q)
                            KBSR_ADDR: memout_d = {kb_ready_q, 15'b0};
                            KBDR_ADDR: begin
                                memout_d     = {8'b0, kbdr_q};
                                kbdr_rd_done = 1'b1;
                            end
                            DSR_ADDR:  memout_d = {dready_q, 15'b0};
                            DDR_ADDR:  memout_d = 16'h0000;
                            default:   memout_d = ext_rdata;
                        endcase
                    end else if (addr_q == DDR_ADDR && dready_q) begin
                        ddr_wr_go = 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A KBDR read clears ready first, so a character arriving on the
        // same edge is captured rather than dropped.
        kb_ready_after_rd = kb_ready_q & ~kbdr_rd_done;
        kb_ready_d        = kb_ready_after_rd;
        if (kb_valid && !kb_ready_after_rd) begin
            kbdr_d     = kb_data;
            kb_ready_d = 1'b1;
        end

        // dready is only ever 1 while dd_valid is 0, so a DDR write and a
        // display handshake never act on the same edge.
        if (dd_valid_q && dd_ready) begin
            dd_valid_d = 1'b0;
            dready_d   = 1'b1;
        end
        if (ddr_wr_go) begin
            dd_data_d  = wdata_q[7:0];
            dd_valid_d = 1'b1;
            dready_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            we_q       <= 1'b0;
            memout_q   <= 16'h0000;
            r_q        <= 1'b0;
            ext_ce_q   <= 1'b0;
            ext_we_q   <= 1'b0;
            kbdr_q     <= 8'h00;
            kb_ready_q <= 1'b0;
            dready_q   <= 1'b1;
            dd_valid_q <= 1'b0;
            dd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            memout_q   <= memout_d;
            r_q        <= r_d;
            ext_ce_q   <= ext_ce_d;
            ext_we_q   <= ext_we_d;
            kbdr_q     <= kbdr_d;
            kb_ready_q <= kb_ready_d;
            dready_q   <= dready_d;
            dd_valid_q <= dd_valid_d;
            dd_data_q  <= dd_data_d;
        end
    end

    // The latched request doubles as the external address/data bus; it is
    // only qualified by ext_ce/ext_we during external accesses.
    assign memOut    = memout_q;
    assign R         = r_q;
    assign ext_ce    = ext_ce_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = addr_q;
    assign ext_wdata = wdata_q;
    assign dd_valid  = dd_valid_q;
    assign dd_data   = dd_data_q;

endmodule
